// File: rtl/paralelo_arbitro.sv
// paralelo_arbitro: four-channel byte scheduler in front of paralelo_serial.
// After reset it sends N_TRAIN COM characters so the deserializer can align.
// It then shares the serializer among four show-ahead FIFOs in round-robin
// order, with up to BURST_MAX bytes per grant. IDLE_CHAR is sent when no
// channel has data.
// Ports:
//   clk_4f     byte-rate clock, rising edge
//   reset      asynchronous active-high reset
//   enable     low: no new grant, the current burst stops after its byte
//   fifo_empty bit i high = FIFO i empty
//   fifo_data  FIFO i head byte on [8i+7:8i]
//   pop        one-hot combinational pop of FIFO i
//   data_out   registered byte to the serializer
//   valid_out  registered, high only for channel data bytes
//   chan_id    registered source channel of data_out
//   training   registered, high while the TRAIN state is active
module paralelo_arbitro #(
  parameter int unsigned N_TRAIN   = 4,
  parameter int unsigned BURST_MAX = 4,
  parameter logic [7:0]  COM_CHAR  = 8'hBC,
  parameter logic [7:0]  IDLE_CHAR = 8'h7C
) (
  input  logic        clk_4f,
  input  logic        reset,
  input  logic        enable,
  input  logic [3:0]  fifo_empty,
  input  logic [31:0] fifo_data,
  output logic [3:0]  pop,
  output logic [7:0]  data_out,
  output logic        valid_out,
  output logic [1:0]  chan_id,
  output logic        training
);

  localparam int unsigned TCNT_W = $clog2(N_TRAIN + 1);
  localparam int unsigned BCNT_W = 4;
  localparam logic [TCNT_W-1:0] TRAIN_LAST = TCNT_W'(N_TRAIN - 1);
  localparam logic [BCNT_W-1:0] BURST_LIM  = BCNT_W'(BURST_MAX);

  localparam logic [1:0] S_TRAIN = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_SERVE = 2'd2;

  logic [1:0]        state, state_d;
  logic [TCNT_W-1:0] train_cnt, train_cnt_d;
  logic [BCNT_W-1:0] burst_cnt, burst_cnt_d;
  logic [1:0]        ptr, ptr_d;
  logic [1:0]        grant, grant_d;
  logic [7:0]        data_d;
  logic              valid_d;
  logic [1:0]        chan_d;
  logic              training_d;
  logic [3:0]        pop_c;

  logic [1:0]        base;
  logic              arb_found;
  logic [1:0]        arb_idx;
  logic              sel_valid;
  logic [1:0]        sel;
  logic [BCNT_W-1:0] sel_cnt;
  logic [BCNT_W-1:0] sel_cnt_inc;

  // First non-empty channel at or after base, wrapping 3 -> 0.
  function automatic logic [2:0] pick_next(input logic [3:0] req, input logic [1:0] start);
    logic       found;
    logic [1:0] idx;
    logic [1:0] cand;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = start + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  // Next-state, pop and registered-output decode.
  always_comb begin
    state_d     = state;
    train_cnt_d = train_cnt;
    burst_cnt_d = burst_cnt;
    ptr_d       = ptr;
    grant_d     = grant;
    data_d      = IDLE_CHAR;
    valid_d     = 1'b0;
    chan_d      = chan_id;
    training_d  = 1'b0;
    pop_c       = 4'b0000;
    sel_valid   = 1'b0;
    sel         = 2'd0;
    sel_cnt     = '0;
    sel_cnt_inc = '0;

    // A drained grant hands priority to the channel after it.
    base = (state == S_SERVE) ? grant + 2'd1 : ptr;
    {arb_found, arb_idx} = pick_next(~fifo_empty, base);

    case (state)
      S_TRAIN: begin
        data_d      = COM_CHAR;
        training_d  = 1'b1;
        train_cnt_d = train_cnt + TCNT_W'(1);
        if (train_cnt == TRAIN_LAST) begin
          state_d     = S_IDLE;
          training_d  = 1'b0;
          train_cnt_d = '0;
        end
      end
      S_IDLE: begin
        if (enable && arb_found) begin
          sel_valid = 1'b1;
          sel       = arb_idx;
        end
      end
      S_SERVE: begin
        if (!fifo_empty[grant]) begin
          sel_valid = 1'b1;
          sel       = grant;
          sel_cnt   = burst_cnt;
        end else begin
          // Granted FIFO ran dry: close the grant and arbitrate as IDLE would.
          ptr_d   = grant + 2'd1;
          state_d = S_IDLE;
          if (enable && arb_found) begin
            sel_valid = 1'b1;
            sel       = arb_idx;
          end
        end
      end
      default: state_d = S_TRAIN;
    endcase

    if (sel_valid) begin
      pop_c       = 4'b0001 << sel;
      data_d      = fifo_data[{sel, 3'b000} +: 8];
      valid_d     = 1'b1;
      chan_d      = sel;
      sel_cnt_inc = sel_cnt + BCNT_W'(1);
      burst_cnt_d = sel_cnt_inc;
      // Ending the grant via IDLE lets the next grant pop in the very next cycle.
      if (sel_cnt_inc == BURST_LIM || !enable) begin
        ptr_d   = sel + 2'd1;
        state_d = S_IDLE;
      end else begin
        grant_d = sel;
        state_d = S_SERVE;
      end
    end
  end

  assign pop = reset ? 4'b0000 : pop_c;

  // State and registered outputs.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state     <= S_TRAIN;
      train_cnt <= '0;
      burst_cnt <= '0;
      ptr       <= 2'd0;
      grant     <= 2'd0;
      data_out  <= COM_CHAR;
      valid_out <= 1'b0;
      chan_id   <= 2'd0;
      training  <= 1'b1;
    end else begin
      state     <= state_d;
      train_cnt <= train_cnt_d;
      burst_cnt <= burst_cnt_d;
      ptr       <= ptr_d;
      grant     <= grant_d;
      data_out  <= data_d;
      valid_out <= valid_d;
      chan_id   <= chan_d;
      training  <= training_d;
    end
  end

endmodule

// File: tb/tb_paralelo_arbitro.sv
// Testbench for paralelo_arbitro: bench-side FIFO queues feed the DUT, an
// expected-byte scoreboard is filled in the required grant order when
// stimulus is loaded, and a monitor compares every valid output byte.
module tb_paralelo_arbitro;

  logic        clk_4f;
  logic        reset;
  logic        enable;
  logic [3:0]  fifo_empty;
  logic [31:0] fifo_data;
  logic [3:0]  pop;
  logic [7:0]  data_out;
  logic        valid_out;
  logic [1:0]  chan_id;
  logic        training;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] ch;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       sb_e;
  logic [7:0] fq0[$];
  logic [7:0] fq1[$];
  logic [7:0] fq2[$];
  logic [7:0] fq3[$];
  logic [3:0] pop_s;
  logic [3:0] fe_s;

  paralelo_arbitro dut (
    .clk_4f     (clk_4f),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .pop        (pop),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .chan_id    (chan_id),
    .training   (training)
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  // Pop legality at the edge, scoreboard compare after the edge.
  always @(posedge clk_4f) begin
    pop_s = pop;
    fe_s  = fifo_empty;
    if (!reset && pop_s != 4'b0000) begin
      checks++;
      if (!$onehot(pop_s) || (pop_s & fe_s) != 4'b0000) begin
        failures++;
        $display("FAIL pop_legal pop=%b fifo_empty=%b", pop_s, fe_s);
      end
    end
    #2;
    if (!reset && valid_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got data=%h ch=%0d with nothing expected", data_out, chan_id);
      end else begin
        sb_e = exp_q.pop_front();
        if (data_out !== sb_e.data || chan_id !== sb_e.ch) begin
          failures++;
          $display("FAIL sb_byte got data=%h ch=%0d expected data=%h ch=%0d",
                   data_out, chan_id, sb_e.data, sb_e.ch);
        end
      end
    end
  end

  task automatic refresh();
    fifo_empty = {fq3.size() == 0, fq2.size() == 0, fq1.size() == 0, fq0.size() == 0};
    fifo_data  = 32'h0;
    if (fq0.size() > 0) fifo_data[7:0]   = fq0[0];
    if (fq1.size() > 0) fifo_data[15:8]  = fq1[0];
    if (fq2.size() > 0) fifo_data[23:16] = fq2[0];
    if (fq3.size() > 0) fifo_data[31:24] = fq3[0];
  endtask

  task automatic push_fifo(input int ch, input logic [7:0] b);
    case (ch)
      0: fq0.push_back(b);
      1: fq1.push_back(b);
      2: fq2.push_back(b);
      default: fq3.push_back(b);
    endcase
  endtask

  task automatic expect_byte(input int ch, input logic [7:0] b);
    exp_t e;
    e.data = b;
    e.ch   = 2'(ch);
    exp_q.push_back(e);
  endtask

  // One clock: consume popped heads, then return 3 time units after the edge.
  task automatic step();
    logic [3:0] p;
    @(posedge clk_4f);
    p = pop;
    #1;
    if (p[0] && fq0.size() > 0) void'(fq0.pop_front());
    if (p[1] && fq1.size() > 0) void'(fq1.pop_front());
    if (p[2] && fq2.size() > 0) void'(fq2.pop_front());
    if (p[3] && fq3.size() > 0) void'(fq3.pop_front());
    refresh();
    #2;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    enable = 1'b1;
    fq0.delete(); fq1.delete(); fq2.delete(); fq3.delete();
    exp_q.delete();
    refresh();
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    refresh();
    step();
    checks++; if (data_out !== 8'hBC) begin failures++; $display("FAIL rst_data got %h expected bc", data_out); end
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rst_valid got %b expected 0", valid_out); end
    checks++; if (chan_id !== 2'd0) begin failures++; $display("FAIL rst_chan got %0d expected 0", chan_id); end
    checks++; if (training !== 1'b1) begin failures++; $display("FAIL rst_training got %b expected 1", training); end
    checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL rst_pop got %b expected 0000", pop); end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (data_out !== 8'hBC || training !== (i < 4) || valid_out !== 1'b0 || pop !== 4'b0000) begin
        failures++;
        $display("FAIL train_byte%0d got data=%h trn=%b val=%b pop=%b expected data=bc trn=%b val=0 pop=0000",
                 i, data_out, training, valid_out, pop, (i < 4));
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (data_out !== 8'h7C || valid_out !== 1'b0 || training !== 1'b0 || pop !== 4'b0000) begin
        failures++;
        $display("FAIL idle_after_train got data=%h val=%b trn=%b pop=%b expected data=7c val=0 trn=0 pop=0000",
                 data_out, valid_out, training, pop);
      end
    end
  endtask

  task automatic test_single_channel();
    apply_reset();
    push_fifo(1, 8'hA1); push_fifo(1, 8'hA2);
    expect_byte(1, 8'hA1); expect_byte(1, 8'hA2);
    refresh();
    #1;
    checks++; if (pop !== 4'b0010) begin failures++; $display("FAIL single_pop1 got %b expected 0010", pop); end
    step();
    checks++; if (pop !== 4'b0010) begin failures++; $display("FAIL single_pop2 got %b expected 0010", pop); end
    step();
    checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL single_pop_end got %b expected 0000", pop); end
    step();
    checks++;
    if (data_out !== 8'h7C || valid_out !== 1'b0) begin
      failures++; $display("FAIL single_idle got data=%h val=%b expected 7c/0", data_out, valid_out);
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_drained left=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_round_robin();
    int first, last, nvalid;
    apply_reset();
    for (int ch = 0; ch < 4; ch++)
      for (int i = 0; i < 6; i++) push_fifo(ch, 8'(8'h80 + ch * 16 + i));
    for (int pass = 0; pass < 2; pass++)
      for (int ch = 0; ch < 4; ch++)
        for (int k = 0; k < (pass == 0 ? 4 : 2); k++) expect_byte(ch, 8'(8'h80 + ch * 16 + pass * 4 + k));
    refresh();
    first = -1; last = -1; nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (valid_out) begin
        if (nvalid == 0) first = c;
        last = c;
        nvalid++;
      end
    end
    checks++; if (nvalid != 24) begin failures++; $display("FAIL rr_count got %0d expected 24", nvalid); end
    checks++; if (last - first + 1 != 24) begin failures++; $display("FAIL rr_no_gap span=%0d expected 24", last - first + 1); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rr_drained left=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_enable();
    apply_reset();
    for (int i = 0; i < 4; i++) push_fifo(2, 8'(8'hC0 + i));
    push_fifo(3, 8'hD0); push_fifo(3, 8'hD1);
    expect_byte(2, 8'hC0); expect_byte(2, 8'hC1);
    expect_byte(3, 8'hD0); expect_byte(3, 8'hD1);
    expect_byte(2, 8'hC2); expect_byte(2, 8'hC3);
    refresh();
    #1;
    checks++; if (pop !== 4'b0100) begin failures++; $display("FAIL en_first_pop got %b expected 0100", pop); end
    step();
    enable = 1'b0;
    #1;
    checks++; if (pop !== 4'b0100) begin failures++; $display("FAIL en_second_pop got %b expected 0100", pop); end
    step();
    checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL en_hold_pop got %b expected 0000", pop); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (data_out !== 8'h7C || valid_out !== 1'b0 || pop !== 4'b0000) begin
        failures++; $display("FAIL en_idle got data=%h val=%b pop=%b expected 7c/0/0000", data_out, valid_out, pop);
      end
    end
    enable = 1'b1;
    #1;
    checks++; if (pop !== 4'b1000) begin failures++; $display("FAIL en_resume_ch3 got %b expected 1000", pop); end
    for (int i = 0; i < 12; i++) step();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL en_drained left=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    for (int i = 0; i < 6; i++) push_fifo(0, 8'(8'hE0 + i));
    expect_byte(0, 8'hE0);
    refresh();
    step();
    checks++; if (pop !== 4'b0001) begin failures++; $display("FAIL rmb_pop_before got %b expected 0001", pop); end
    reset = 1'b1;
    #1;
    checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL rmb_pop_zero got %b expected 0000", pop); end
    checks++;
    if (data_out !== 8'hBC || valid_out !== 1'b0 || training !== 1'b1) begin
      failures++; $display("FAIL rmb_outputs got data=%h val=%b trn=%b expected bc/0/1", data_out, valid_out, training);
    end
    for (int i = 1; i < 6; i++) expect_byte(0, 8'(8'hE0 + i));
    step();
    reset = 1'b0;
    #1;
    checks++; if (pop !== 4'b0000) begin failures++; $display("FAIL rmb_release_pop got %b expected 0000", pop); end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++;
      if (data_out !== 8'hBC || pop !== (i == 4 ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL rmb_train%0d got data=%h pop=%b expected data=bc pop=%b",
                 i, data_out, pop, (i == 4 ? 4'b0001 : 4'b0000));
      end
    end
    for (int i = 0; i < 12; i++) step();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rmb_drained left=%0d expected 0", exp_q.size()); end
  endtask

  task automatic test_empty_during_burst();
    int first, last, nvalid;
    apply_reset();
    push_fifo(0, 8'hF0);
    push_fifo(1, 8'hF1); push_fifo(1, 8'hF2); push_fifo(1, 8'hF3);
    expect_byte(0, 8'hF0);
    expect_byte(1, 8'hF1); expect_byte(1, 8'hF2); expect_byte(1, 8'hF3);
    refresh();
    first = -1; last = -1; nvalid = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (valid_out) begin
        if (nvalid == 0) first = c;
        last = c;
        nvalid++;
      end
    end
    checks++; if (nvalid != 4) begin failures++; $display("FAIL eb_count got %0d expected 4", nvalid); end
    checks++; if (last - first + 1 != 4) begin failures++; $display("FAIL eb_no_gap span=%0d expected 4", last - first + 1); end
    // Pointer should now sit at 2: ch2 must win over ch1.
    push_fifo(1, 8'h91); push_fifo(2, 8'hA2);
    expect_byte(2, 8'hA2); expect_byte(1, 8'h91);
    refresh();
    #1;
    checks++; if (pop !== 4'b0100) begin failures++; $display("FAIL eb_ptr2 got %b expected 0100", pop); end
    for (int i = 0; i < 6; i++) step();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL eb_drained left=%0d expected 0", exp_q.size()); end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    refresh();
    test_reset();
    test_single_channel();
    test_round_robin();
    test_enable();
    test_reset_mid_burst();
    test_empty_during_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish checks=%0d", checks);
    $fatal(1);
  end

endmodule

// File: doc/paralelo_arbitro.md
Name: paralelo_arbitro

Overview:
- Four-channel scheduler that feeds the byte input of the parallel-to-serial converter from four show-ahead byte FIFOs.
- After reset it runs a link-training phase that sends COM characters so the deserializer can align.
- It then shares the serializer among the four channels with round-robin order and a per-grant burst limit.
- When no channel holds data, it drives idle characters with valid low.
- It runs in the clk_4f byte-rate domain and sits directly upstream of paralelo_serial (data_out -> in_serial, valid_out -> valid_in).

Parameters:
- N_TRAIN, 4: number of COM bytes sent after reset before data service starts.
- BURST_MAX, 4: maximum consecutive bytes popped from one channel per grant (range 1..15).
- COM_CHAR, 8'hBC: training character.
- IDLE_CHAR, 8'h7C: character driven when no data is available.

Ports:
- clk_4f  input  1  byte-rate clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  when low, no new grant is started; the current burst ends after its current byte.
- fifo_empty  input  4  bit i high = FIFO i empty.
- fifo_data  input  32  FIFO i head byte on bits [8i+7:8i]; valid whenever fifo_empty[i] is low.
- pop  output  4  one-hot, combinational; consumes the head of FIFO i this cycle.
- data_out  output  8  registered byte to the serializer.
- valid_out  output  1  registered; high only for channel data bytes.
- chan_id  output  2  registered; source channel of data_out, meaningful when valid_out is high.
- training  output  1  registered; high while the TRAIN state is active.

Behaviour:
- Reset values (asynchronous, while reset is high):
  - data_out=COM_CHAR, valid_out=0, chan_id=0, training=1, pop=0.
  - state=TRAIN, train counter=0, burst counter=0, round-robin pointer=0 (channel 0 has highest priority first).
- Latency: a byte popped in cycle t appears on data_out/valid_out/chan_id after edge t+1.
- States:
  - TRAIN:
    - Each cycle, data_out<=COM_CHAR, valid_out<=0, pop=0, train counter increments.
    - After the N_TRAIN-th COM byte is registered, go to IDLE and set training<=0.
    - fifo inputs and enable are ignored.
  - IDLE:
    - data_out<=IDLE_CHAR, valid_out<=0, pop=0.
    - If enable=1 and any fifo_empty bit is low, grant the first non-empty channel at or after the pointer, modulo 4.
    - That grant pops in the same cycle; the state moves to SERVE with burst counter=1.
    - So no bubble is inserted between IDLE and the first data byte.
  - SERVE (granted channel g):
    - If fifo_empty[g]=0, then pop[g]=1 and data_out<=fifo_data[g], valid_out<=1, chan_id<=g, burst counter increments.
    - The grant ends when any of these holds:
      - the burst counter reaches BURST_MAX after this pop;
      - fifo_empty[g]=1;
      - enable=0.
    - When the grant ends, the pointer becomes g+1 mod 4.
    - Arbitration runs again in the same cycle (back-to-back grants, no gap) if enable=1 and another channel has data.
    - Otherwise go to IDLE.
    - If fifo_empty[g]=1 on entry to a SERVE cycle, there is no pop for g. The block re-arbitrates that cycle as IDLE would, and drives IDLE_CHAR if nothing is granted.
- pop is always one-hot or zero. It is never asserted for an empty FIFO, or in TRAIN or during reset.
- Pointer wrap-around: 3 -> 0.
- A single active channel with continuous data is re-granted immediately after each burst; this is legal and causes no gap.
- Reset mid-burst: outputs return to reset values at once, no pop is issued, and training restarts with the full N_TRAIN COM bytes.

Test Plan:
- Reset then idle: all FIFOs empty -> 4 cycles data_out=BC with training=1, then 7C with valid_out=0; pop stays 0.
- Single channel: FIFO1 holds A1,A2 -> after training, pop[1] for 2 cycles; data_out=A1,A2 with valid=1, chan_id=1; then 7C.
- Round-robin and burst limit:
  - Stimulus: all four FIFOs hold 6 bytes, BURST_MAX=4.
  - Required grant order: ch0 x4, ch1 x4, ch2 x4, ch3 x4, ch0 x2, ch1 x2, ch2 x2, ch3 x2, with no idle bytes between grants.
- Enable deassert: enable drops during the 2nd byte of a ch2 burst -> that byte completes, then 7C; resuming enable grants ch3 first if it has data.
- Reset mid-burst: reset is asserted while pop[0]=1 -> pop=0 immediately, data_out=BC; 4 COM bytes follow before any pop.
- Empty during burst: ch0 holds 1 byte, ch1 holds 3 -> ch0 x1 then ch1 x3 back-to-back; pointer ends at 2.
